ibex_rf_erase_ctrl: RTL

Sequencer that drives the `sec_ers_i` erase strobes of the renaming flip-flop register file, so the register file's erase port can be used safely without a combinational mask from the core. It accepts an architectural-register erase mask through a valid/ready handshake. It then issues the erase over one or more cycles in groups of `ErsPerCycle` registers, skipping empty groups. A core write to a pending register retires that register's erase, because the rename write already zeroes the old physical register. It sits between the ID/EX stage (erase instruction issue) and the register file.

---
 rtl/ibex_rf_erase_ctrl.sv | 125 ++++++++++++
 1 files changed

// File: rtl/ibex_rf_erase_ctrl.sv
// ============================================================================
//  Module   : ibex_rf_erase_ctrl
//  Purpose  : Sequencer for the erase strobes (sec_ers_i) of the renaming
//             flip-flop register file. It accepts an architectural-register
//             erase mask through a valid/ready handshake. It then issues the
//             erase in groups of ErsPerCycle registers and skips empty groups.
//             A core write to a pending register retires that register's
//             erase, because the rename write already zeroes the old
//             physical register.
//  Ports    : clk_i, rst_i            clock / synchronous active-high reset
//             req_valid_i/_ready_o    erase request handshake
//             req_mask_i[31:0]        bit i requests erasure of xi
//             we_a_i, waddr_a_i       monitored register-file write port
//             sec_ers_o[31:0]         erase strobes to the register file
//             busy_o, done_o, err_o   status (done_o / err_o are 1-cycle pulses)
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ibex_rf_erase_ctrl #(
    parameter bit RV32E       = 1'b0,
    parameter int ErsPerCycle = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [31:0] req_mask_i,
    input  logic        we_a_i,
    input  logic [4:0]  waddr_a_i,
    output logic [31:0] sec_ers_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o
);

    localparam int          c_ngrp       = 32 / ErsPerCycle;
    // x0 is hard-wired zero and never erased; RV32E has no x16..x31.
    localparam logic [31:0] c_legal_mask = RV32E ? 32'h0000_FFFE : 32'hFFFF_FFFE;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ERASE = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pend_q, pend_d;
    logic        err_q, err_d;

    logic [31:0]       w_wr_clr;
    logic [31:0]       w_eff;
    logic [31:0]       w_sel;
    logic [c_ngrp-1:0] w_grp_nz;
    logic [c_ngrp-1:0] w_lower_nz;

    // A rename write to a pending register already zeroes the old physical
    // register, so that bit no longer needs an erase strobe.
    assign w_wr_clr = (we_a_i && (waddr_a_i != 5'd0)) ? (32'd1 << waddr_a_i) : 32'd0;
    assign w_eff    = pend_q & ~w_wr_clr;

    // Pick the lowest-indexed non-empty group: a group is selected when it is
    // non-empty and every group below it is empty.
    for (genvar g = 0; g < c_ngrp; g++) begin : g_grp
        assign w_grp_nz[g] = |w_eff[g*ErsPerCycle +: ErsPerCycle];
        if (g == 0) begin : g_first
            assign w_lower_nz[g] = 1'b0;
        end else begin : g_rest
            assign w_lower_nz[g] = |w_grp_nz[g-1:0];
        end
        assign w_sel[g*ErsPerCycle +: ErsPerCycle] =
            (w_grp_nz[g] && !w_lower_nz[g]) ? w_eff[g*ErsPerCycle +: ErsPerCycle]
                                            : {ErsPerCycle{1'b0}};
    end

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    pend_d  = req_mask_i & c_legal_mask;
                    // Bit 0 alone is silently dropped; only x16..x31 under
                    // RV32E counts as an illegal request.
                    err_d   = RV32E && (req_mask_i[31:16] != 16'd0);
                    state_d = (pend_d == 32'd0) ? S_DONE : S_ERASE;
                end
            end
            S_ERASE: begin
                pend_d  = w_eff & ~w_sel;
                state_d = (pend_d == 32'd0) ? S_DONE : S_ERASE;
            end
            S_DONE: begin
                err_d   = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            pend_q  <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            err_q   <= err_d;
        end
    end

    // Status outputs decode directly from the state register.
    assign req_ready_o = (state_q == S_IDLE);
    assign busy_o      = (state_q != S_IDLE);
    assign done_o      = (state_q == S_DONE);
    assign err_o       = (state_q == S_DONE) && err_q;
    assign sec_ers_o   = (state_q == S_ERASE) ? w_sel : 32'd0;

endmodule

`default_nettype wire
